// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: state codes,
// condition codes, op classes, ALU commands and datapath select values.
package mcc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXECR    = 4'd2;
  localparam logic [3:0] S_EXECI    = 4'd3;
  localparam logic [3:0] S_ALUWB    = 4'd4;
  localparam logic [3:0] S_MEMADR   = 4'd5;
  localparam logic [3:0] S_MEMREAD  = 4'd6;
  localparam logic [3:0] S_MEMWB    = 4'd7;
  localparam logic [3:0] S_MEMWRITE = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] SRCA_REG   = 2'b00;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  function automatic logic [1:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_ADD: return ALU_ADD;
      CMD_SUB: return ALU_SUB;
      CMD_CMP: return ALU_SUB;
      CMD_AND: return ALU_AND;
      CMD_ORR: return ALU_ORR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory bundle. master = controller side,
// slave = datapath side.
interface multicycle_controller_if #(parameter int FLAG_W = 4);
  logic [31:0]       instr;
  logic [FLAG_W-1:0] alu_flags;
  logic              mem_ready;
  logic              mem_req;
  logic              mem_write;
  logic              adr_src;
  logic              ir_write;
  logic              pc_write;
  logic              reg_write;
  logic [1:0]        alu_src_a;
  logic [1:0]        alu_src_b;
  logic [1:0]        result_src;
  logic [1:0]        alu_control;
  logic [FLAG_W-1:0] flags_q;
  logic              retire;
  logic              illegal;

  modport master (
    input  instr, alu_flags, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_control, flags_q,
           retire, illegal
  );

  modport slave (
    output instr, alu_flags, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, alu_control, flags_q,
           retire, illegal
  );
endinterface

// File: rtl/multicycle_controller_cond_check.sv
// Condition-code evaluation against committed NZCV flags.
// COND_FULL_EN selects the full ARM condition set; otherwise only AL and EQ.
module cond_check
  import mcc_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);
  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = i_flags;

`ifdef COND_FULL_EN
  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      COND_EQ: o_pass = w_z;
      COND_NE: o_pass = !w_z;
      COND_CS: o_pass = w_c;
      COND_CC: o_pass = !w_c;
      COND_MI: o_pass = w_n;
      COND_PL: o_pass = !w_n;
      COND_VS: o_pass = w_v;
      COND_VC: o_pass = !w_v;
      COND_HI: o_pass = w_c && !w_z;
      COND_LS: o_pass = !w_c || w_z;
      COND_GE: o_pass = (w_n == w_v);
      COND_LT: o_pass = (w_n != w_v);
      COND_GT: o_pass = !w_z && (w_n == w_v);
      COND_LE: o_pass = w_z || (w_n != w_v);
      COND_AL: o_pass = 1'b1;
      default: o_pass = 1'b0;
    endcase
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, w_n, w_c, w_v};
  assign o_pass = (i_cond == COND_AL) || ((i_cond == COND_EQ) && w_z);
`endif
endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer: drives datapath selects/enables, the memory handshake
// and the NZCV register. Condition set is chosen by COND_FULL_EN in cond_check.
module multicycle_controller
  import mcc_pkg::*;
#(
  parameter int CMD_W  = 4,
  parameter int FLAG_W = 4
) (
  input logic                   clk,
  input logic                   reset,
  multicycle_controller_if.master bus
);
  logic [3:0]        r_state, w_next;
  logic [FLAG_W-1:0] r_flags;
  logic              w_pass;
  logic [3:0]        w_cond;
  logic [1:0]        w_op;
  logic              w_imm, w_sl;
  logic [CMD_W-1:0]  w_cmd;
  logic [3:0]        w_rd;
  logic [1:0]        w_alu_op;
  logic              w_wb_en, w_rd_pc;
  logic              w_unused;

  assign w_cond   = bus.instr[31:28];
  assign w_op     = bus.instr[27:26];
  assign w_imm    = bus.instr[25];
  assign w_cmd    = bus.instr[24:21];
  assign w_sl     = bus.instr[20];
  assign w_rd     = bus.instr[15:12];
  assign w_unused = &{1'b0, bus.instr[19:16], bus.instr[11:0]};
  assign w_alu_op = alu_decode(w_cmd);
  assign w_wb_en  = (w_cmd != CMD_CMP);
  assign w_rd_pc  = (w_rd == 4'hF);

  cond_check u_cond (
    .i_cond  (w_cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
  logic       w_reg_write, w_retire, w_illegal;
  logic [1:0] w_src_a, w_src_b, w_res_src, w_alu_ctl;

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_adr_src   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_reg_write = 1'b0;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    w_src_a     = SRCA_REG;
    w_src_b     = SRCB_REG;
    w_res_src   = RES_ALUOUT;
    w_alu_ctl   = ALU_ADD;
    // Reset forces every control low, including a mem_req mid-handshake.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          w_mem_req = 1'b1;
          w_src_a   = SRCA_PC;
          w_src_b   = SRCB_FOUR;
          w_res_src = RES_ALU;
          if (bus.mem_ready) begin
            w_ir_write = 1'b1;
            w_pc_write = 1'b1;
            w_next     = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_pass) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            case (w_op)
              OP_DP:   w_next = w_imm ? S_EXECI : S_EXECR;
              OP_MEM:  w_next = S_MEMADR;
              OP_BR:   w_next = S_BRANCH;
              default: begin
                w_illegal = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
              end
            endcase
          end
        end
        S_EXECR: begin
          w_alu_ctl = w_alu_op;
          w_next    = S_ALUWB;
        end
        S_EXECI: begin
          w_src_b   = SRCB_IMM;
          w_alu_ctl = w_alu_op;
          w_next    = S_ALUWB;
        end
        S_ALUWB: begin
          // ALU keeps computing so alu_flags are valid for the flag update.
          w_src_b     = w_imm ? SRCB_IMM : SRCB_REG;
          w_alu_ctl   = w_alu_op;
          w_reg_write = w_wb_en && !w_rd_pc;
          w_pc_write  = w_wb_en && w_rd_pc;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
        end
        S_MEMADR: begin
          w_src_b = SRCB_IMM;
          w_next  = w_sl ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          w_mem_req = 1'b1;
          w_adr_src = 1'b1;
          if (bus.mem_ready) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          w_reg_write = 1'b1;
          w_res_src   = RES_RDATA;
          w_retire    = 1'b1;
          w_next      = S_FETCH;
        end
        S_MEMWRITE: begin
          w_mem_req   = 1'b1;
          w_mem_write = 1'b1;
          w_adr_src   = 1'b1;
          if (bus.mem_ready) begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end
        S_BRANCH: begin
          w_src_a    = SRCA_PC;
          w_src_b    = SRCB_IMM;
          w_res_src  = RES_ALU;
          w_pc_write = 1'b1;
          w_retire   = 1'b1;
          w_next     = S_FETCH;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // C and V only carry meaning for the arithmetic ALU ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else if (r_state == S_ALUWB && w_sl) begin
      r_flags[3:2] <= bus.alu_flags[3:2];
      if (w_alu_op == ALU_ADD || w_alu_op == ALU_SUB)
        r_flags[1:0] <= bus.alu_flags[1:0];
    end
  end

  assign bus.mem_req     = w_mem_req;
  assign bus.mem_write   = w_mem_write;
  assign bus.adr_src     = w_adr_src;
  assign bus.ir_write    = w_ir_write;
  assign bus.pc_write    = w_pc_write;
  assign bus.reg_write   = w_reg_write;
  assign bus.alu_src_a   = w_src_a;
  assign bus.alu_src_b   = w_src_b;
  assign bus.result_src  = w_res_src;
  assign bus.alu_control = w_alu_ctl;
  assign bus.flags_q     = r_flags;
  assign bus.retire      = w_retire;
  assign bus.illegal     = w_illegal;
endmodule
